// File: rtl/dns_ip_tx.sv
// ---------------------------------------------------------------------------
// dns_ip_tx
//
// Purpose:
//   Takes one complete DNS message, delivered as a wide packet vector with
//   its IPv4/UDP addressing, and presents it downstream as a UDP header
//   beat followed by a byte-wide AXI-Stream payload.
//   Every frame goes through three phases:
//     IDLE          - s_dns_ready high. The first valid packet is captured.
//     WRITE_HDR     - m_udp_hdr_valid high until the header is taken.
//     WRITE_PAYLOAD - payload bytes 0..N-1 are sent, with tlast on byte N-1.
//
// Optional feature (macro DNS_TX_LEN_CHECK_EN):
//   Defined   : a packet with length 0, or with length greater than
//               MAX_BYTES, is consumed and dropped. error_bad_length pulses
//               for one cycle, in the cycle after accept.
//   Undefined : error_bad_length is tied to 0. A length greater than
//               MAX_BYTES is clamped to MAX_BYTES, and a length of 0 is
//               sent as a single byte.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   s_dns_valid/ready         packet-buffer handshake
//   s_udp_src_ip/dst_ip       IPv4 addresses (32)
//   s_dns_src_port/dst_port   UDP ports (16); a source port of 0 is sent as
//                             DNS_PORT
//   s_dns_length              DNS payload length in bytes (16)
//   s_dns_pkt                 payload; byte i is at bits
//                             [8*MAX_BYTES-1-8i -: 8]
//   m_udp_hdr_valid/ready     header handshake
//   m_udp_*                   header fields; m_udp_length = payload + 8
//   m_udp_payload_axis_*      byte stream (tdata/tvalid/tready/tlast/tuser)
//   busy                      high while a frame is in progress
//   error_bad_length          one-cycle pulse when a bad length is rejected
// ---------------------------------------------------------------------------
module dns_ip_tx #(
   parameter int          MAX_BYTES = 512,
   parameter logic [15:0] DNS_PORT  = 16'd53
) (
   input  logic                   clk,
   input  logic                   rst,

   input  logic                   s_dns_valid,
   output logic                   s_dns_ready,
   input  logic [31:0]            s_udp_src_ip,
   input  logic [31:0]            s_udp_dst_ip,
   input  logic [15:0]            s_dns_src_port,
   input  logic [15:0]            s_dns_dst_port,
   input  logic [15:0]            s_dns_length,
   input  logic [8*MAX_BYTES-1:0] s_dns_pkt,

   output logic                   m_udp_hdr_valid,
   input  logic                   m_udp_hdr_ready,
   output logic [15:0]            m_udp_source_port,
   output logic [15:0]            m_udp_dest_port,
   output logic [15:0]            m_udp_length,
   output logic [31:0]            m_udp_source_ip,
   output logic [31:0]            m_udp_dest_ip,

   output logic [7:0]             m_udp_payload_axis_tdata,
   output logic                   m_udp_payload_axis_tvalid,
   input  logic                   m_udp_payload_axis_tready,
   output logic                   m_udp_payload_axis_tlast,
   output logic                   m_udp_payload_axis_tuser,

   output logic                   busy,
   output logic                   error_bad_length
);

   localparam int          PKT_W   = 8 * MAX_BYTES;
   localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);
   localparam logic [15:0] UDP_HDR = 16'd8;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_HDR,
      WRITE_PAYLOAD
   } state_t;

   state_t            r_state;
   logic              r_ready;
   logic              r_hdr_valid;
   logic [15:0]       r_src_port;
   logic [15:0]       r_dst_port;
   logic [15:0]       r_udp_len;
   logic [31:0]       r_src_ip;
   logic [31:0]       r_dst_ip;
   logic [15:0]       r_len;          // effective payload length of the frame
   logic [15:0]       r_remaining;    // bytes still to send after the one on tdata
   logic [PKT_W-1:0]  r_pkt;          // shifts left; the top byte is always the next byte
   logic [7:0]        r_tdata;
   logic              r_tvalid;
   logic              r_tlast;
   logic              r_busy;

   logic              w_accept;
   logic              w_beat;
   logic              w_len_bad;
   logic [15:0]       w_len_eff;
   logic [15:0]       w_src_port_eff;
   logic [7:0]        w_top_byte;

   assign w_accept   = s_dns_valid && r_ready;
   assign w_beat     = r_tvalid && m_udp_payload_axis_tready;
   assign w_top_byte = r_pkt[PKT_W-1 -: 8];

`ifdef DNS_TX_LEN_CHECK_EN
   assign w_len_bad = (s_dns_length == 16'd0) || (s_dns_length > MAX_LEN);
`else
   assign w_len_bad = 1'b0;
`endif

   // Length seen by the datapath. When the check is on, a bad length never
   // reaches this point, so the clamp has no effect.
   always_comb begin
      w_len_eff = s_dns_length;
      if (s_dns_length == 16'd0) begin
         w_len_eff = 16'd1;
      end else if (s_dns_length > MAX_LEN) begin
         w_len_eff = MAX_LEN;
      end
   end

   assign w_src_port_eff = (s_dns_src_port == 16'd0) ? DNS_PORT : s_dns_src_port;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ready     <= 1'b0;
         r_hdr_valid <= 1'b0;
         r_src_port  <= '0;
         r_dst_port  <= '0;
         r_udp_len   <= '0;
         r_src_ip    <= '0;
         r_dst_ip    <= '0;
         r_len       <= '0;
         r_remaining <= '0;
         r_pkt       <= '0;
         r_tdata     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // r_ready is still 0 in the first cycle after reset. It
               // rises here, so no packet can be accepted in that cycle.
               r_ready <= 1'b1;
               if (w_accept && !w_len_bad) begin
                  r_state     <= WRITE_HDR;
                  r_ready     <= 1'b0;
                  r_hdr_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_src_port  <= w_src_port_eff;
                  r_dst_port  <= s_dns_dst_port;
                  r_src_ip    <= s_udp_src_ip;
                  r_dst_ip    <= s_udp_dst_ip;
                  r_udp_len   <= w_len_eff + UDP_HDR;
                  r_len       <= w_len_eff;
                  r_pkt       <= s_dns_pkt;
               end
            end

            WRITE_HDR: begin
               if (r_hdr_valid && m_udp_hdr_ready) begin
                  r_state     <= WRITE_PAYLOAD;
                  r_hdr_valid <= 1'b0;
                  // Preload byte 0, so tvalid can rise in the first payload cycle.
                  r_tvalid    <= 1'b1;
                  r_tdata     <= w_top_byte;
                  r_tlast     <= (r_len == 16'd1);
                  r_remaining <= r_len - 16'd1;
                  r_pkt       <= r_pkt << 8;
               end
            end

            WRITE_PAYLOAD: begin
               if (w_beat) begin
                  if (r_tlast) begin
                     // Go back to IDLE ready to accept, with no idle gap.
                     r_state  <= IDLE;
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_busy   <= 1'b0;
                     r_ready  <= 1'b1;
                  end else begin
                     r_tdata     <= w_top_byte;
                     r_tlast     <= (r_remaining == 16'd1);
                     r_remaining <= r_remaining - 16'd1;
                     r_pkt       <= r_pkt << 8;
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef DNS_TX_LEN_CHECK_EN
   logic r_err;

   // A rejected packet is taken like any other accept. The FSM stays in
   // IDLE, and the error pulse is seen in the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_accept && w_len_bad && (r_state == IDLE);
      end
   end

   assign error_bad_length = r_err;
`else
   assign error_bad_length = 1'b0;
`endif

   assign s_dns_ready               = r_ready;
   assign m_udp_hdr_valid           = r_hdr_valid;
   assign m_udp_source_port         = r_src_port;
   assign m_udp_dest_port           = r_dst_port;
   assign m_udp_length              = r_udp_len;
   assign m_udp_source_ip           = r_src_ip;
   assign m_udp_dest_ip             = r_dst_ip;
   assign m_udp_payload_axis_tdata  = r_tdata;
   assign m_udp_payload_axis_tvalid = r_tvalid;
   assign m_udp_payload_axis_tlast  = r_tlast;
   assign m_udp_payload_axis_tuser  = 1'b0;
   assign busy                      = r_busy;

endmodule

// File: tb/tb_dns_ip_tx.sv
// ---------------------------------------------------------------------------
// tb_dns_ip_tx
//
// Purpose:
//   Self-checking bench for dns_ip_tx.
//   A table of frames is run through the design. Each entry holds the
//   stimulus and hand-computed results: the header length, the source port
//   and the number of bytes.
//   Hand-written sequences cover:
//     - the reset state;
//     - a reset in the middle of a frame;
//     - bad lengths, in builds where DNS_TX_LEN_CHECK_EN is defined.
//   Payload byte i of each frame is seed+i, so the expected bytes can be
//   computed without reading the DUT.
// ---------------------------------------------------------------------------
module tb_dns_ip_tx;

   localparam int MAXB = 512;
   localparam int PW   = 8 * MAXB;

   logic           clk = 1'b0;
   logic           rst;
   logic           s_dns_valid;
   logic           s_dns_ready;
   logic [31:0]    s_udp_src_ip;
   logic [31:0]    s_udp_dst_ip;
   logic [15:0]    s_dns_src_port;
   logic [15:0]    s_dns_dst_port;
   logic [15:0]    s_dns_length;
   logic [PW-1:0]  s_dns_pkt;
   logic           m_udp_hdr_valid;
   logic           m_udp_hdr_ready;
   logic [15:0]    m_udp_source_port;
   logic [15:0]    m_udp_dest_port;
   logic [15:0]    m_udp_length;
   logic [31:0]    m_udp_source_ip;
   logic [31:0]    m_udp_dest_ip;
   logic [7:0]     tdata;
   logic           tvalid;
   logic           tready;
   logic           tlast;
   logic           tuser;
   logic           busy;
   logic           error_bad_length;

   dns_ip_tx #(.MAX_BYTES(MAXB), .DNS_PORT(16'd53)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .s_dns_valid               (s_dns_valid),
      .s_dns_ready               (s_dns_ready),
      .s_udp_src_ip              (s_udp_src_ip),
      .s_udp_dst_ip              (s_udp_dst_ip),
      .s_dns_src_port            (s_dns_src_port),
      .s_dns_dst_port            (s_dns_dst_port),
      .s_dns_length              (s_dns_length),
      .s_dns_pkt                 (s_dns_pkt),
      .m_udp_hdr_valid           (m_udp_hdr_valid),
      .m_udp_hdr_ready           (m_udp_hdr_ready),
      .m_udp_source_port         (m_udp_source_port),
      .m_udp_dest_port           (m_udp_dest_port),
      .m_udp_length              (m_udp_length),
      .m_udp_source_ip           (m_udp_source_ip),
      .m_udp_dest_ip             (m_udp_dest_ip),
      .m_udp_payload_axis_tdata  (tdata),
      .m_udp_payload_axis_tvalid (tvalid),
      .m_udp_payload_axis_tready (tready),
      .m_udp_payload_axis_tlast  (tlast),
      .m_udp_payload_axis_tuser  (tuser),
      .busy                      (busy),
      .error_bad_length          (error_bad_length)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] len;
      logic [15:0] sp;
      logic [15:0] dp;
      logic [31:0] sip;
      logic [31:0] dip;
      logic [7:0]  seed;
      int          mode;      // 0: tready always 1; 1: tready toggles 1/0
      int          hstall;    // cycles with m_udp_hdr_ready held at 0
      logic [15:0] exp_len;
      logic [15:0] exp_sp;
      int          exp_n;
   } vec_t;

   vec_t vecs[8];
   int   n_vec;
   int   n_cmp = 0;
   int   n_mis = 0;
   int   overlap_cnt = 0;
   int   err_pulse_cnt = 0;

   always @(negedge clk) begin
      if (m_udp_hdr_valid && tvalid) overlap_cnt++;
      if (error_bad_length) err_pulse_cnt++;
   end

   initial begin
      #(10 * 50000);
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int cyc;
      cyc = 0;
      while (s_dns_ready !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("in_ready", s_dns_ready, 1);
   endtask

   // Sends one frame and checks it. If abort_after > 0, rst is asserted
   // after that many payload bytes have been transferred.
   task automatic send_frame(input vec_t v, input int abort_after);
      logic [PW-1:0] pkt;
      int            cyc, idx, byte_err, stall_err, hdr_err, held, done;
      logic [7:0]    held_d;
      logic          held_l;
      for (int i = 0; i < MAXB; i++) pkt[PW-1-8*i -: 8] = v.seed + 8'(i);
      wait_ready();
      s_dns_valid    = 1'b1;
      s_udp_src_ip   = v.sip;
      s_udp_dst_ip   = v.dip;
      s_dns_src_port = v.sp;
      s_dns_dst_port = v.dp;
      s_dns_length   = v.len;
      s_dns_pkt      = pkt;
      @(posedge clk); #1;
      // Scramble the inputs after accept. The frame must come from the captured copy.
      s_dns_valid    = 1'b0;
      s_udp_src_ip   = ~v.sip;
      s_udp_dst_ip   = ~v.dip;
      s_dns_src_port = ~v.sp;
      s_dns_dst_port = ~v.dp;
      s_dns_length   = 16'd3;
      s_dns_pkt      = ~pkt;
      chk("hdr_valid", m_udp_hdr_valid, 1);
      chk("hdr_udp_len", m_udp_length, v.exp_len);
      chk("hdr_src_port", m_udp_source_port, v.exp_sp);
      chk("hdr_dst_port", m_udp_dest_port, v.dp);
      chk("hdr_src_ip", m_udp_source_ip, v.sip);
      chk("hdr_dst_ip", m_udp_dest_ip, v.dip);
      chk("hdr_busy", busy, 1);
      chk("hdr_in_ready", s_dns_ready, 0);
      chk("hdr_no_tvalid", tvalid, 0);
      hdr_err = 0;
      for (int k = 0; k < v.hstall; k++) begin
         m_udp_hdr_ready = 1'b0;
         @(posedge clk); #1;
         if (m_udp_hdr_valid !== 1'b1 || m_udp_length !== v.exp_len ||
             m_udp_source_port !== v.exp_sp || m_udp_dest_port !== v.dp ||
             m_udp_source_ip !== v.sip || m_udp_dest_ip !== v.dip ||
             tvalid !== 1'b0 || s_dns_ready !== 1'b0)
            hdr_err++;
      end
      if (v.hstall > 0) chk("hdr_stall_stable", hdr_err, 0);
      m_udp_hdr_ready = 1'b1;
      @(posedge clk); #1;
      m_udp_hdr_ready = 1'b0;
      chk("hdr_taken", m_udp_hdr_valid, 0);
      chk("tvalid_rise", tvalid, 1);

      idx = 0; cyc = 0; done = 0; held = 0; byte_err = 0; stall_err = 0;
      while (done == 0 && cyc < 2000) begin
         if (abort_after > 0 && idx == abort_after) break;
         if (held != 0 && (tvalid !== 1'b1 || tdata !== held_d || tlast !== held_l))
            stall_err++;
         if (tuser !== 1'b0 || s_dns_ready !== 1'b0 || busy !== 1'b1) byte_err++;
         tready = (v.mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         held = 0;
         if (tvalid && tready) begin
            if (tdata !== v.seed + 8'(idx)) byte_err++;
            if (tlast !== (idx == v.exp_n - 1)) byte_err++;
            if (tlast) done = 1;
            idx++;
         end else if (tvalid) begin
            held   = 1;
            held_d = tdata;
            held_l = tlast;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("payload_data", byte_err, 0);
      if (abort_after > 0) begin
         chk("abort_nbytes", idx, abort_after);
         rst = 1'b1;
         @(posedge clk); #1;
         chk("abort_tvalid", tvalid, 0);
         chk("abort_tlast", tlast, 0);
         chk("abort_busy", busy, 0);
         rst = 1'b0;
         @(posedge clk); #1;
         chk("abort_ready", s_dns_ready, 1);
         $display("frame aborted after %0d bytes", idx);
      end else begin
         chk("frame_done", done, 1);
         chk("nbytes", idx, v.exp_n);
         if (v.mode == 0) chk("back_to_back", cyc, v.exp_n);
         if (v.mode == 1) chk("stall_hold", stall_err, 0);
         chk("end_ready", s_dns_ready, 1);
         chk("end_busy", busy, 0);
         chk("end_tvalid", tvalid, 0);
         $display("frame len=%0d udp_len=%0d src_port=%0d bytes=%0d cycles=%0d",
                  v.len, m_udp_length, m_udp_source_port, idx, cyc);
      end
      tready = 1'b0;
   endtask

`ifdef DNS_TX_LEN_CHECK_EN
   task automatic bad_len(input logic [15:0] len);
      wait_ready();
      s_dns_valid  = 1'b1;
      s_dns_length = len;
      @(posedge clk); #1;
      s_dns_valid  = 1'b0;
      chk("err_pulse", error_bad_length, 1);
      chk("err_no_hdr", m_udp_hdr_valid, 0);
      chk("err_not_busy", busy, 0);
      @(posedge clk); #1;
      chk("err_one_cycle", error_bad_length, 0);
      chk("err_no_hdr2", m_udp_hdr_valid, 0);
      chk("err_no_tvalid", tvalid, 0);
      $display("bad length %0d rejected", len);
   endtask
`endif

   initial begin
      vec_t v;
      rst = 1'b1;
      s_dns_valid = 1'b0;
      s_udp_src_ip = '0;
      s_udp_dst_ip = '0;
      s_dns_src_port = '0;
      s_dns_dst_port = '0;
      s_dns_length = '0;
      s_dns_pkt = '0;
      m_udp_hdr_ready = 1'b0;
      tready = 1'b0;

      n_vec = 0;
      vecs[n_vec++] = '{16'd12, 16'd53,   16'd1234, 32'hC0A80001, 32'hC0A80002, 8'h00, 0, 0,  16'd20, 16'd53,   12};
      vecs[n_vec++] = '{16'd4,  16'd1000, 16'd2000, 32'h0A000001, 32'h0A000002, 8'hA0, 1, 0,  16'd12, 16'd1000, 4};
      vecs[n_vec++] = '{16'd8,  16'd777,  16'd53,   32'h01020304, 32'h05060708, 8'h30, 0, 10, 16'd16, 16'd777,  8};
      vecs[n_vec++] = '{16'd1,  16'd0,    16'd4444, 32'hDEADBEEF, 32'hCAFEF00D, 8'h5A, 0, 0,  16'd9,  16'd53,   1};
`ifndef DNS_TX_LEN_CHECK_EN
      vecs[n_vec++] = '{16'd600, 16'd99,  16'd53,   32'h11111111, 32'h22222222, 8'h10, 0, 0,  16'd520, 16'd99,  512};
      vecs[n_vec++] = '{16'd0,   16'd88,  16'd53,   32'h33333333, 32'h44444444, 8'hE7, 0, 0,  16'd9,   16'd88,  1};
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", s_dns_ready, 0);
      chk("rst_hdr_valid", m_udp_hdr_valid, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", error_bad_length, 0);
      chk("rst_udp_len", m_udp_length, 0);
      chk("rst_src_port", m_udp_source_port, 0);
      chk("rst_src_ip", m_udp_source_ip, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", s_dns_ready, 1);

      for (int i = 0; i < n_vec; i++) send_frame(vecs[i], 0);

      // Reset in the middle of a frame, then a clean frame after it.
      v = '{16'd12, 16'd2000, 16'd53, 32'h0A0A0A0A, 32'h0B0B0B0B, 8'h40, 0, 0, 16'd20, 16'd2000, 12};
      send_frame(v, 3);
      v = '{16'd5, 16'd0, 16'd6000, 32'h0C0C0C0C, 32'h0D0D0D0D, 8'h80, 1, 2, 16'd13, 16'd53, 5};
      send_frame(v, 0);

`ifdef DNS_TX_LEN_CHECK_EN
      bad_len(16'd600);
      bad_len(16'd0);
      v = '{16'd2, 16'd10, 16'd20, 32'h01010101, 32'h02020202, 8'hF0, 0, 0, 16'd10, 16'd10, 2};
      send_frame(v, 0);
`else
      chk("err_never", err_pulse_cnt, 0);
`endif
      chk("hdr_payload_overlap", overlap_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/dns_ip_tx.md
DNS_IP_TX -- requirements
Module: dns_ip_tx

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 512, maximum DNS payload bytes (packet vector width = 8*MAX_BYTES).
REQ-002 SHALL have parameter DNS_PORT, default 16'd53, default source port when s_dns_src_port is 0.
REQ-003 SHALL have port clk input 1, clock; reset rst is synchronous, active-high; clock clk.
REQ-004 SHALL have port rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports s_dns_valid input 1 and s_dns_ready output 1, packet-buffer handshake.
REQ-006 SHALL have ports s_udp_src_ip input 32 and s_udp_dst_ip input 32, IPv4 addresses.
REQ-007 SHALL have ports s_dns_src_port input 16 and s_dns_dst_port input 16, UDP ports.
REQ-008 SHALL have port s_dns_length input 16, DNS payload length in bytes.
REQ-009 SHALL have port s_dns_pkt input 8*MAX_BYTES, byte i at bits [8*MAX_BYTES-1-8i -: 8].
REQ-010 SHALL have ports m_udp_hdr_valid output 1 and m_udp_hdr_ready input 1, header handshake.
REQ-011 SHALL have ports m_udp_source_port, m_udp_dest_port, m_udp_length output 16 each, and m_udp_source_ip, m_udp_dest_ip output 32 each, header fields.
REQ-012 SHALL have ports m_udp_payload_axis_tdata output 8, tvalid output 1, tready input 1, tlast output 1, tuser output 1, payload stream.
REQ-013 SHALL have ports busy output 1 (frame in progress) and error_bad_length output 1 (one-cycle pulse).

Function
REQ-014 SHALL implement states IDLE, WRITE_HDR, WRITE_PAYLOAD.
REQ-015 SHALL drive s_dns_ready=1 only in IDLE; accept on s_dns_valid&&s_dns_ready.
REQ-016 SHALL on accept capture all s_* inputs into internal registers; later input changes have no effect.
REQ-017 SHALL assert m_udp_hdr_valid the cycle after accept (state WRITE_HDR), fields held stable until m_udp_hdr_valid&&m_udp_hdr_ready.
REQ-018 SHALL set m_udp_length = payload length + 8 (16-bit, no overflow possible within MAX_BYTES); source port = captured port, or DNS_PORT when captured port is 0.
REQ-019 SHALL enter WRITE_PAYLOAD the cycle after header acceptance; tvalid rises that cycle.
REQ-020 SHALL emit bytes 0..N-1 in order; tdata/tlast held stable while tvalid&&!tready.
REQ-021 SHALL assert tlast only on byte N-1; tuser always 0.
REQ-022 SHALL sustain one byte per cycle while tready=1.
REQ-023 SHALL return to IDLE the cycle after last-byte transfer; s_dns_ready=1 that cycle (no idle gap beyond it).
REQ-024 SHALL drive busy=1 in WRITE_HDR and WRITE_PAYLOAD, 0 in IDLE.
REQ-025 SHALL not assert m_udp_hdr_valid and tvalid of the same frame in the same cycle.

Reset
REQ-026 SHALL on rst: state IDLE; s_dns_ready, m_udp_hdr_valid, tvalid, tlast, busy, error_bad_length = 0; header field outputs 0.
REQ-027 SHALL on rst mid-frame abandon the frame next cycle with no tlast; s_dns_ready=1 the cycle after rst deasserts.

Configuration
REQ-028 SHALL, with DNS_TX_LEN_CHECK_EN defined, consume packets with length 0 or >MAX_BYTES without emitting header or payload, pulse error_bad_length one cycle after accept, and remain in IDLE.
REQ-029 SHALL, without DNS_TX_LEN_CHECK_EN, tie error_bad_length to 0, clamp length >MAX_BYTES to MAX_BYTES, and treat length 0 as 1 (m_udp_length=9).

Verification
REQ-030 SHALL cover: length 12, bytes 0x00..0x0B, ports 53/1234, ready always 1 -> header m_udp_length=20 one cycle after accept; 12 bytes back-to-back, tlast on 0x0B.
REQ-031 SHALL cover: length 4, tready toggling 1/0 each cycle -> bytes stable while stalled; exactly 4 transfers, tlast on 4th.
REQ-032 SHALL cover: m_udp_hdr_ready held 0 for 10 cycles -> header fields stable, tvalid=0, s_dns_ready=0 throughout.
REQ-033 SHALL cover: src port 0, length 1 -> m_udp_source_port=53, single byte with tlast=1.
REQ-034 SHALL cover: length 600 -> with macro, error_bad_length pulse, no header; without macro, m_udp_length=520, 512 bytes.
REQ-035 SHALL cover: rst asserted after 3 payload bytes -> tvalid=0 next cycle, no tlast; new packet after reset transmitted correctly.
